// File: rtl/io_port_pkg.sv
// Shared helpers for the I/O port mapper: address-window decode functions and
// the write delay-line entry type.
package io_port_pkg;

   // Widest port index any instance may use; the delay-line entry carries it.
   localparam int MAX_PORT_IDX_W = 8;

   typedef struct packed {
      logic                      valid;
      logic [MAX_PORT_IDX_W-1:0] idx;
   } wr_entry_t;

   function automatic logic addr_in_window(
      input logic [31:0] addr,
      input logic [31:0] base,
      input logic [31:0] count
   );
      return (addr >= base) && (addr < (base + count));
   endfunction

   function automatic logic [MAX_PORT_IDX_W-1:0] port_index(
      input logic [31:0] addr,
      input logic [31:0] base
   );
      logic [31:0] offset;
      offset = addr - base;
      return offset[MAX_PORT_IDX_W-1:0];
   endfunction

endpackage

// File: rtl/io_addr_decoder.sv
// Decodes one address against a port window and selects that port's
// Empty/Full bit; the EF bit is forced low for addresses that map to RAM.
module io_addr_decoder
   import io_port_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int PORT_COUNT = 4,
   parameter int BASE_ADDR  = 1020,
   parameter int IDX_WIDTH  = 2
) (
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [PORT_COUNT-1:0] i_ef,
   output logic                  o_is_io,
   output logic [IDX_WIDTH-1:0]  o_idx,
   output logic                  o_ef_sel
);

   always_comb begin
      o_is_io  = addr_in_window(32'(i_addr), 32'(BASE_ADDR), 32'(PORT_COUNT));
      o_idx    = IDX_WIDTH'(port_index(32'(i_addr), 32'(BASE_ADDR)));
      o_ef_sel = o_is_io & i_ef[o_idx];
   end

endmodule

// File: rtl/shift_reg.sv
// Generic fixed-depth shift register with synchronous clear; one entry in and
// one entry out per cycle.
module shift_reg #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] r_stage [DEPTH];

   // NOTE: every stage is cleared on reset (not just the head) because entries
   // carry valid bits; a stale entry would fire a write after reset.
   // NOTE: non-blocking assignments let each stage take its predecessor's old
   // value, which is what makes this a shift and not a single copy.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      end else begin
         r_stage[0] <= i_data;
         for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/io_port_mapper.sv
// Pipelined I/O port mapper for one operand memory: registered readiness and
// one-hot enables, read-path mux, and a write delay line aligned to the ALU.
module io_port_mapper
   import io_port_pkg::*;
#(
   parameter int WORD_WIDTH            = 36,
   parameter int ADDR_WIDTH            = 10,
   parameter int READ_PORT_COUNT       = 4,
   parameter int READ_PORT_BASE_ADDR   = 1020,
   parameter int READ_PORT_ADDR_WIDTH  = 2,
   parameter int WRITE_PORT_COUNT      = 4,
   parameter int WRITE_PORT_BASE_ADDR  = 1020,
   parameter int WRITE_PORT_ADDR_WIDTH = 2,
   parameter int WRITE_DELAY           = 4
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  in_valid,
   input  logic [ADDR_WIDTH-1:0]                 read_addr,
   input  logic [ADDR_WIDTH-1:0]                 write_addr,
   input  logic                                  write_en,
   input  logic [READ_PORT_COUNT-1:0]            read_EF,
   input  logic [WRITE_PORT_COUNT-1:0]           write_EF,
   input  logic [READ_PORT_COUNT*WORD_WIDTH-1:0] read_data_IO,
   input  logic [WORD_WIDTH-1:0]                 read_data_RAM,
   input  logic [WORD_WIDTH-1:0]                 write_data,
   output logic                                  io_ready,
   output logic [READ_PORT_COUNT-1:0]            read_rden,
   output logic [WORD_WIDTH-1:0]                 read_data,
   output logic [WRITE_PORT_COUNT-1:0]           write_wren,
   output logic [WORD_WIDTH-1:0]                 write_data_IO
);

   localparam int DL_DEPTH = WRITE_DELAY - 1;
   localparam int DL_WIDTH = 1 + WRITE_PORT_ADDR_WIDTH;

   logic                             w_rd_io;
   logic [READ_PORT_ADDR_WIDTH-1:0]  w_ri;
   logic                             w_rd_has_data;
   logic                             w_wr_io;
   logic [WRITE_PORT_ADDR_WIDTH-1:0] w_wi;
   logic                             w_wr_full;
   logic                             w_ready;

   logic                             r_io_ready;
   logic [READ_PORT_COUNT-1:0]       r_read_rden;
   logic                             r_rd_io;
   logic [READ_PORT_ADDR_WIDTH-1:0]  r_ri;
   logic                             r_wr_valid;
   logic [WRITE_PORT_ADDR_WIDTH-1:0] r_wi;
   logic [WORD_WIDTH-1:0]            r_read_data;
   logic [WRITE_PORT_COUNT-1:0]      r_write_wren;
   logic [WORD_WIDTH-1:0]            r_write_data_IO;

   logic [DL_WIDTH-1:0]              w_dl_in;
   logic [DL_WIDTH-1:0]              w_dl_out;
   wr_entry_t                        w_head;
   logic [WRITE_PORT_COUNT-1:0]      w_wren_next;
   logic [WORD_WIDTH-1:0]            w_io_word;

   io_addr_decoder #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .PORT_COUNT (READ_PORT_COUNT),
      .BASE_ADDR  (READ_PORT_BASE_ADDR),
      .IDX_WIDTH  (READ_PORT_ADDR_WIDTH)
   ) u_rd_dec (
      .i_addr   (read_addr),
      .i_ef     (read_EF),
      .o_is_io  (w_rd_io),
      .o_idx    (w_ri),
      .o_ef_sel (w_rd_has_data)
   );

   io_addr_decoder #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .PORT_COUNT (WRITE_PORT_COUNT),
      .BASE_ADDR  (WRITE_PORT_BASE_ADDR),
      .IDX_WIDTH  (WRITE_PORT_ADDR_WIDTH)
   ) u_wr_dec (
      .i_addr   (write_addr),
      .i_ef     (write_EF),
      .o_is_io  (w_wr_io),
      .o_idx    (w_wi),
      .o_ef_sel (w_wr_full)
   );

   // A stall on either side annuls the whole instruction.
   assign w_ready = in_valid
                  & (~w_rd_io | w_rd_has_data)
                  & (~(write_en & w_wr_io) | ~w_wr_full);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_io_ready  <= 1'b0;
         r_read_rden <= '0;
         r_rd_io     <= 1'b0;
         r_ri        <= '0;
         r_wr_valid  <= 1'b0;
         r_wi        <= '0;
      end else begin
         r_io_ready  <= w_ready;
         r_read_rden <= (w_ready & w_rd_io) ? (READ_PORT_COUNT'(1) << w_ri) : '0;
         r_rd_io     <= w_rd_io;
         r_ri        <= w_ri;
         r_wr_valid  <= w_ready & write_en & w_wr_io;
         r_wi        <= w_wi;
      end
   end

   assign w_dl_in = {r_wr_valid, r_wi};

   shift_reg #(
      .WIDTH (DL_WIDTH),
      .DEPTH (DL_DEPTH)
   ) u_write_delay (
      .clock  (clock),
      .reset  (reset),
      .i_data (w_dl_in),
      .o_data (w_dl_out)
   );

   // NOTE: every variable gets a default before the conditional so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      w_head       = '0;
      w_head.valid = w_dl_out[DL_WIDTH-1];
      w_head.idx   = MAX_PORT_IDX_W'(w_dl_out[WRITE_PORT_ADDR_WIDTH-1:0]);
      w_wren_next  = '0;
      if (w_head.valid) w_wren_next = WRITE_PORT_COUNT'(1) << w_head.idx;
   end

   assign w_io_word = read_data_IO[int'(r_ri)*WORD_WIDTH +: WORD_WIDTH];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_read_data     <= '0;
         r_write_wren    <= '0;
         r_write_data_IO <= '0;
      end else begin
         r_read_data  <= r_rd_io ? w_io_word : read_data_RAM;
         r_write_wren <= w_wren_next;
         if (w_head.valid) r_write_data_IO <= write_data;
      end
   end

   assign io_ready      = r_io_ready;
   assign read_rden     = r_read_rden;
   assign read_data     = r_read_data;
   assign write_wren    = r_write_wren;
   assign write_data_IO = r_write_data_IO;

endmodule

// File: tb/tb_io_port_mapper.sv
// Scoreboard bench for io_port_mapper: directed per-cycle vectors push expected
// responses into queues that a negedge monitor pops and compares.
module tb_io_port_mapper;

   localparam int WW   = 36;
   localparam int AW   = 10;
   localparam int NP   = 4;
   localparam int BASE = 1020;

   logic            clock = 1'b0;
   logic            reset;
   logic            in_valid;
   logic [AW-1:0]   read_addr;
   logic [AW-1:0]   write_addr;
   logic            write_en;
   logic [NP-1:0]   read_EF;
   logic [NP-1:0]   write_EF;
   logic [NP*WW-1:0] read_data_IO;
   logic [WW-1:0]   read_data_RAM;
   logic [WW-1:0]   write_data;
   logic            io_ready;
   logic [NP-1:0]   read_rden;
   logic [WW-1:0]   read_data;
   logic [NP-1:0]   write_wren;
   logic [WW-1:0]   write_data_IO;

   always #5 clock = ~clock;

   io_port_mapper #(
      .WORD_WIDTH            (WW),
      .ADDR_WIDTH            (AW),
      .READ_PORT_COUNT       (NP),
      .READ_PORT_BASE_ADDR   (BASE),
      .READ_PORT_ADDR_WIDTH  (2),
      .WRITE_PORT_COUNT      (NP),
      .WRITE_PORT_BASE_ADDR  (BASE),
      .WRITE_PORT_ADDR_WIDTH (2),
      .WRITE_DELAY           (4)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .in_valid      (in_valid),
      .read_addr     (read_addr),
      .write_addr    (write_addr),
      .write_en      (write_en),
      .read_EF       (read_EF),
      .write_EF      (write_EF),
      .read_data_IO  (read_data_IO),
      .read_data_RAM (read_data_RAM),
      .write_data    (write_data),
      .io_ready      (io_ready),
      .read_rden     (read_rden),
      .read_data     (read_data),
      .write_wren    (write_wren),
      .write_data_IO (write_data_IO)
   );

   typedef struct {
      bit          rst;
      bit          vld;
      int          raddr;
      logic [3:0]  rd_ef;
      int          waddr;
      bit          we;
      logic [3:0]  wr_ef;
      logic [35:0] ram;
      logic [35:0] wdata;
   } vec_t;

   typedef struct { int due; logic rdy; logic [3:0] rden; } rdy_exp_t;
   typedef struct { int due; logic [35:0] data; } rd_exp_t;
   typedef struct { int due; logic [3:0] wren; logic [35:0] data; } wr_exp_t;

   vec_t     vecs[$];
   rdy_exp_t q_rdy[$];
   rd_exp_t  q_rd[$];
   wr_exp_t  q_wr[$];

   logic [35:0] io_word [4];
   int total = 0;
   int bad   = 0;
   int cyc   = -1;

   assign read_data_IO = {io_word[3], io_word[2], io_word[1], io_word[0]};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endtask

   task automatic add(input bit rst, input bit vld, input int raddr, input logic [3:0] rd_ef,
                      input int waddr, input bit we, input logic [3:0] wr_ef,
                      input logic [35:0] ram, input logic [35:0] wdata);
      vec_t v;
      v.rst = rst; v.vld = vld; v.raddr = raddr; v.rd_ef = rd_ef;
      v.waddr = waddr; v.we = we; v.wr_ef = wr_ef; v.ram = ram; v.wdata = wdata;
      vecs.push_back(v);
   endtask

   task automatic idle(input bit rst);
      add(rst, 1'b0, 0, 4'h0, 0, 1'b0, 4'h0, {4'h5, 32'(vecs.size())}, 36'h0);
   endtask

   function automatic bit in_win(input int a);
      return (a >= BASE) && (a < BASE + NP);
   endfunction

   function automatic int pidx(input int a);
      return (a - BASE) & 3;
   endfunction

   function automatic bit rst_in(input int k, input int n);
      for (int j = k; j <= k + n; j++)
         if (j < vecs.size() && vecs[j].rst) return 1'b1;
      return 1'b0;
   endfunction

   // Expected responses derived straight from the decode/readiness rules.
   task automatic push_expect(input int k);
      vec_t v;
      bit rd_io, wr_io, ready;
      int ri, wi;
      v     = vecs[k];
      rd_io = in_win(v.raddr);
      wr_io = in_win(v.waddr);
      ri    = pidx(v.raddr);
      wi    = pidx(v.waddr);
      ready = v.vld && (!rd_io || v.rd_ef[ri]) && (!(v.we && wr_io) || !v.wr_ef[wi]);
      q_rdy.push_back('{k + 1, (!v.rst && ready),
                        (!v.rst && ready && rd_io) ? 4'(1 << ri) : 4'h0});
      if (!rst_in(k, 1))
         q_rd.push_back('{k + 2, rd_io ? io_word[ri] : v.ram});
      if (ready && v.we && wr_io && !rst_in(k, 4))
         q_wr.push_back('{k + 5, 4'(1 << wi), v.wdata});
   endtask

   rdy_exp_t e_rdy;
   rd_exp_t  e_rd;
   wr_exp_t  e_wr;

   always @(negedge clock) begin
      if (cyc >= 0) begin
         if (q_rdy.size() > 0 && q_rdy[0].due == cyc) begin
            e_rdy = q_rdy.pop_front();
            check("io_ready", 64'(io_ready), 64'(e_rdy.rdy));
            check("read_rden", 64'(read_rden), 64'(e_rdy.rden));
         end
         if (q_rd.size() > 0 && q_rd[0].due == cyc) begin
            e_rd = q_rd.pop_front();
            check("read_data", 64'(read_data), 64'(e_rd.data));
         end
         if (q_wr.size() > 0 && q_wr[0].due == cyc) begin
            e_wr = q_wr.pop_front();
            check("write_wren", 64'(write_wren), 64'(e_wr.wren));
            check("write_data_IO", 64'(write_data_IO), 64'(e_wr.data));
         end else begin
            check("write_wren_idle", 64'(write_wren), 64'h0);
         end
      end
   end

   initial begin
      int n_active;
      io_word[0] = 36'h0000000A0;
      io_word[1] = 36'h1111111B1;
      io_word[2] = 36'h2222222C2;
      io_word[3] = 36'h3333333D3;

      reset = 1'b1; in_valid = 1'b0; read_addr = '0; write_addr = '0; write_en = 1'b0;
      read_EF = '0; write_EF = '0; read_data_RAM = '0; write_data = '0;

      // cycles 0-3: reset, then one quiet cycle
      idle(1); idle(1); idle(1); idle(0);
      // 4: read port 2 with data present
      add(0, 1, 1022, 4'b0100, 0, 0, 4'h0, 36'h500000004, 36'h0);
      idle(0);
      // 6: read port 1 empty stalls a concurrent write to port 0
      add(0, 1, 1021, 4'b1101, 1020, 1, 4'h0, 36'h500000006, 36'h0);
      idle(0);
      // 8: write port 3, data arrives four cycles later
      add(0, 1, 0, 4'h0, 1023, 1, 4'h0, 36'h500000008, 36'h123456789);
      idle(0);
      // 10: RAM read and RAM write with every EF bit blocking
      add(0, 1, 5, 4'h0, 7, 1, 4'hF, 36'hABCDE0123, 36'h0);
      // 11: write port 1 full stalls a RAM read
      add(0, 1, 0, 4'hF, 1021, 1, 4'b0010, 36'h50000000B, 36'h0);
      // 12: I/O read and I/O write together
      add(0, 1, 1023, 4'b1000, 1022, 1, 4'h0, 36'h50000000C, 36'h0FEDCBA98);
      // 13-14: back-to-back reads of port 0
      add(0, 1, 1020, 4'b0001, 0, 0, 4'h0, 36'h50000000D, 36'h0);
      add(0, 1, 1020, 4'b0001, 0, 0, 4'h0, 36'h50000000E, 36'h0);
      // 15: invalid slot
      add(0, 0, 1020, 4'hF, 1020, 1, 4'h0, 36'h50000000F, 36'h0);
      // 16: addresses just below the window are RAM
      add(0, 1, 1019, 4'h0, 1019, 1, 4'hF, 36'h500000010, 36'h0);
      idle(0); idle(0); idle(0);
      // 20-23: four writes to port 0, reset at the fourth
      add(0, 1, 0, 4'h0, 1020, 1, 4'h0, 36'h500000014, 36'h000000101);
      add(0, 1, 0, 4'h0, 1020, 1, 4'h0, 36'h500000015, 36'h000000102);
      add(0, 1, 0, 4'h0, 1020, 1, 4'h0, 36'h500000016, 36'h000000103);
      add(1, 1, 0, 4'h0, 1020, 1, 4'h0, 36'h500000017, 36'h000000104);
      for (int i = 24; i <= 30; i++) idle(0);
      // 31-34: four writes, reset at 37 lets only the first two out
      add(0, 1, 0, 4'h0, 1020, 1, 4'h0, 36'h50000001F, 36'h000000201);
      add(0, 1, 0, 4'h0, 1020, 1, 4'h0, 36'h500000020, 36'h000000202);
      add(0, 1, 0, 4'h0, 1020, 1, 4'h0, 36'h500000021, 36'h000000203);
      add(0, 1, 0, 4'h0, 1020, 1, 4'h0, 36'h500000022, 36'h000000204);
      idle(0); idle(0); idle(1);
      // 38: first instruction after reset
      add(0, 1, 1020, 4'b0001, 1021, 1, 4'h0, 36'h500000026, 36'h3C3C3C3C3);
      for (int i = 39; i <= 42; i++) idle(0);
      n_active = vecs.size();
      for (int i = 0; i < 6; i++) idle(0);

      for (int k = 0; k < vecs.size(); k++) begin
         @(posedge clock);
         #1;
         cyc           = k;
         reset         = vecs[k].rst;
         in_valid      = vecs[k].vld;
         read_addr     = AW'(vecs[k].raddr);
         write_addr    = AW'(vecs[k].waddr);
         write_en      = vecs[k].we;
         read_EF       = vecs[k].rd_ef;
         write_EF      = vecs[k].wr_ef;
         read_data_RAM = (k >= 1) ? vecs[k-1].ram : 36'h0;
         write_data    = (k >= 4) ? vecs[k-4].wdata : 36'h0;
         if (k < n_active) push_expect(k);
         if (k == 3) begin
            @(negedge clock);
            check("reset_io_ready", 64'(io_ready), 64'h0);
            check("reset_read_rden", 64'(read_rden), 64'h0);
            check("reset_read_data", 64'(read_data), 64'h0);
            check("reset_write_wren", 64'(write_wren), 64'h0);
            check("reset_write_data_IO", 64'(write_data_IO), 64'h0);
         end
      end

      @(posedge clock);
      @(negedge clock);
      check("queues_drained", 64'(q_rdy.size() + q_rd.size() + q_wr.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/io_port_mapper.md
# io_port_mapper

Parametrised, pipelined successor to the single-cycle I/O mapper for one operand memory; instantiated once per memory (A, B). It decodes read and write addresses against configurable I/O port windows and selects each port's Empty/Full bit. From those it produces a registered `io_ready` predicate and one-hot read/write enable pulses, then muxes port data into the read path. Write-side decisions are carried through a delay line so they meet the ALU result `WRITE_DELAY` cycles later.

## Interface
- `WORD_WIDTH`, 36, data word width.
- `ADDR_WIDTH`, 10, memory address width.
- `READ_PORT_COUNT`, 4, number of read ports (≥1).
- `READ_PORT_BASE_ADDR`, 1020, first read-port address.
- `READ_PORT_ADDR_WIDTH`, 2, port index width, ≥ clog2(`READ_PORT_COUNT`).
- `WRITE_PORT_COUNT`, 4, number of write ports (≥1).
- `WRITE_PORT_BASE_ADDR`, 1020, first write-port address.
- `WRITE_PORT_ADDR_WIDTH`, 2, port index width.
- `WRITE_DELAY`, 4, cycles from address issue to `write_data` arrival (≥2).

Ports:
- `clock` in 1: the block's single clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: the instruction slot is valid.
- `read_addr` in `ADDR_WIDTH`
- `write_addr` in `ADDR_WIDTH`
- `write_en` in 1: the instruction writes a result.
- `read_EF` in `READ_PORT_COUNT`: 1 = port holds data.
- `write_EF` in `WRITE_PORT_COUNT`: 1 = port full.
- `read_data_IO` in `READ_PORT_COUNT*WORD_WIDTH`: port 0 in the LSBs.
- `read_data_RAM` in `WORD_WIDTH`: valid at cycle 1 (1-cycle RAM).
- `write_data` in `WORD_WIDTH`: valid at cycle `WRITE_DELAY`.
- `io_ready` out 1
- `read_rden` out `READ_PORT_COUNT`: one-hot pulse.
- `read_data` out `WORD_WIDTH`
- `write_wren` out `WRITE_PORT_COUNT`: one-hot pulse.
- `write_data_IO` out `WORD_WIDTH`: shared by all write ports; qualified by `write_wren`.

## Operation
- Decode rule:
  - `rd_io` = `read_addr` in [BASE, BASE+COUNT-1]; port index = `addr - BASE`, truncated to the port index width.
  - The write side decodes the same way. Addresses outside a window are RAM.
- Readiness:
  - `ready = in_valid & (!rd_io | read_EF[ri]) & (!(write_en & wr_io) | !write_EF[wi])`.
  - Non-I/O accesses are always ready.
- When `ready`:
  - `read_rden[ri]` pulses if `rd_io`.
  - A write-delay-line entry {`valid = write_en & wr_io`, `wi`} is pushed.
- When not `ready`: no `rden`, and a pushed entry is marked invalid (annulled). `read_data` is still produced; downstream predication discards it.
- Read mux: `read_data` = the selected `read_data_IO` slice if the delayed `rd_io` is set, else `read_data_RAM`.
- Write: when the delay-line head is valid, `write_wren[wi]` pulses and `write_data_IO` = `write_data`, registered.
- The delay line is a shift register of depth `WRITE_DELAY-1`, entry width 1 + `WRITE_PORT_ADDR_WIDTH`. It is fully pipelined and accepts one entry per cycle.

## Timing
- Cycle 0: inputs sampled and registered.
- Cycle 1: `io_ready`, `read_rden` valid, each a registered 1-cycle pulse.
- Cycle 2: `read_data` valid, registered.
- Cycle `WRITE_DELAY+1`: `write_wren` and `write_data_IO` valid, registered.
- Reset values: `io_ready` 0, `read_rden` 0, `write_wren` 0, `read_data` 0, `write_data_IO` 0. All delay-line valid bits are cleared.
- Reset mid-operation: in-flight writes are dropped, with no `wren` after reset. The first new instruction after reset deasserts is handled normally.
- Back-to-back accesses to the same port on consecutive cycles: each gets its own pulse, with no merging. EF bits are sampled each cycle, so the port must update EF within 1 cycle of a pulse.
- A read and a write to I/O in the same instruction are independent. A stall on either one drops both.
- `in_valid` = 0: `io_ready` 0, no pulses, invalid entry pushed.

## Structure
- Shared package `io_port_pkg`:
  - function `addr_in_window(addr, base, count)`;
  - function `port_index`;
  - the delay-line entry typedef.
- Sub-module `io_addr_decoder` (address → `is_io`, index, EF select), instantiated for read and for write.
- The delay line uses the existing generic shift-register block.

## Test plan
- `read_addr` = 1022, `read_EF` = 4'b0100, `in_valid` = 1 → cycle 1: `io_ready` = 1, `read_rden` = 4'b0100; cycle 2: `read_data` = port-2 word.
- `read_addr` = 1021, `read_EF[1]` = 0 → `io_ready` = 0, `read_rden` = 0, and a concurrent `write_en` to 1020 yields no `write_wren` at cycle `WRITE_DELAY+1`.
- `write_addr` = 1023, `write_EF` = 0, `write_data` = 36'h123456789 at cycle 4 → cycle 5: `write_wren` = 4'b1000, `write_data_IO` = 36'h123456789.
- `read_addr` = 5, `write_addr` = 7 (RAM), all EF bits blocking → `io_ready` = 1, no pulses, `read_data` = `read_data_RAM`.
- Four consecutive writes to 1020, then `reset` asserted at cycle 3 → only the writes already past the delay line produce pulses; `write_wren` = 0 from reset onward.
